// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the execute-stage units: datapath widths and the shift opcode.
package core_config_pkg;

    localparam int XLEN                = 32;
    localparam int MAX_SHIFT_PER_CYCLE = 3;
    localparam int REG_ADDR_W          = 5;
    localparam int SHAMT_W             = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_op_t;

    // The unused encoding 2'b11 behaves as a left shift.
    function automatic shift_op_t decode_op(input logic [1:0] raw);
        shift_op_t op;
        case (raw)
            2'd1:    op = SHIFT_SRL;
            2'd2:    op = SHIFT_SRA;
            default: op = SHIFT_SLL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shifter limited to distances 0..MAX_STEP, selected from a small set of fixed shifts.
module alu_shift_step
    import core_config_pkg::*;
#(
    parameter int XLEN     = core_config_pkg::XLEN,
    parameter int MAX_STEP = core_config_pkg::MAX_SHIFT_PER_CYCLE
) (
    input  logic [XLEN-1:0]    data_in,
    input  shift_op_t          op,
    input  logic [SHAMT_W-1:0] step,
    output logic [XLEN-1:0]    data_out
);

    logic signed [XLEN-1:0] data_s;
    logic        [XLEN-1:0] cand [0:MAX_STEP];

    assign data_s = data_in;

    generate
        for (genvar gi = 0; gi <= MAX_STEP; gi++) begin : g_cand
            logic signed [XLEN-1:0] sra_v;
            assign sra_v    = data_s >>> gi;
            assign cand[gi] = (op == SHIFT_SRL) ? (data_in >> gi) :
                              (op == SHIFT_SRA) ? sra_v           :
                                                  (data_in << gi);
        end
    endgenerate

    always_comb begin
        data_out = data_in;
        for (int i = 0; i <= MAX_STEP; i++) begin
            if (step == SHAMT_W'(i)) begin
                data_out = cand[i];
            end
        end
    end

endmodule

// File: rtl/alu_shift_ctrl.sv
// Multi-cycle shift unit: applies up to MAX_STEP bits of shift per cycle and holds the result
// with a valid/ready handshake until the consumer takes it.
module alu_shift_ctrl
    import core_config_pkg::*;
#(
    parameter int XLEN     = core_config_pkg::XLEN,
    parameter int MAX_STEP = core_config_pkg::MAX_SHIFT_PER_CYCLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [XLEN-1:0]       req_data,
    input  logic [4:0]            req_shamt,
    input  logic [REG_ADDR_W-1:0] req_tag,
    input  logic                  flush,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [XLEN-1:0]       res_data,
    output logic [REG_ADDR_W-1:0] res_tag,
    output logic                  busy
);

    generate
        if (MAX_STEP < 1 || MAX_STEP > 31) begin : g_bad_max_step
            $error("alu_shift_ctrl: MAX_STEP must be within 1..31");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [SHAMT_W-1:0] MAX_STEP_W = SHAMT_W'(MAX_STEP);

    state_t                  state_q, state_d;
    shift_op_t               op_q, op_d;
    logic [XLEN-1:0]         data_q, data_d;
    logic [REG_ADDR_W-1:0]   tag_q, tag_d;
    logic [SHAMT_W-1:0]      rem_q, rem_d;
    logic [SHAMT_W-1:0]      step;
    logic [XLEN-1:0]         shifted;

    assign step = (rem_q < MAX_STEP_W) ? rem_q : MAX_STEP_W;

    alu_shift_step #(
        .XLEN     (XLEN),
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .data_in  (data_q),
        .op       (op_q),
        .step     (step),
        .data_out (shifted)
    );

    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = data_q;
    assign res_tag   = tag_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        tag_d   = tag_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = decode_op(req_op);
                    data_d  = req_data;
                    tag_d   = req_tag;
                    rem_d   = req_shamt;
                    state_d = (req_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - step;
                if (rem_q == step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over both accept and step; a coincident handshake still completes.
        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= SHIFT_SLL;
            data_q  <= '0;
            tag_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            rem_q   <= rem_d;
        end
    end

endmodule
